// File: rtl/mlp_layer_seq.sv
// Time-multiplexed fully-connected layer: NUM_OUT neurons computed on LANES
// shared MAC lanes over NUM_OUT/LANES passes per input frame.
module mlp_layer_seq #(
  parameter int NUM_IN   = 784,
  parameter int NUM_OUT  = 30,
  parameter int LANES    = 10,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 12,
  parameter int LAYER_ID = 1,
  parameter int ACT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [31:0]       cfg_layer,
  input  logic [31:0]       cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_err,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_in,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic [15:0]       y_idx,
  output logic              busy,
  output logic              frame_done
);

  localparam int NUM_PASS = NUM_OUT / LANES;
  localparam int ACC_W    = 2 * DATA_W + $clog2(NUM_IN);
  localparam int CNT_W    = $clog2(NUM_IN + 1);
  localparam int PASS_W   = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
  localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WDEPTH   = NUM_PASS * NUM_IN;
  localparam int WA_W     = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;
  localparam int NB_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [31:0]       W_WORDS   = 32'(NUM_OUT * NUM_IN);
  localparam logic [31:0]       TOTAL     = 32'(NUM_OUT * NUM_IN + NUM_OUT);
  localparam logic [CNT_W-1:0]  LAST_K    = CNT_W'(NUM_IN - 1);
  localparam logic [CNT_W-1:0]  MAC_END   = CNT_W'(NUM_IN);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASS - 1);
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W + 1)'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = -SAT_HI - 1;

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_EMIT} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  mcnt;
  logic [PASS_W-1:0] pass;
  logic [LANE_W-1:0] lane;

  // Weights are banked per lane so every lane reads one word per cycle;
  // neuron n lives in bank n%LANES at row (n/LANES)*NUM_IN + k.
  logic signed [DATA_W-1:0] w_mem [LANES][WDEPTH];
  logic signed [DATA_W-1:0] b_mem [NUM_OUT];
  logic signed [DATA_W-1:0] xbuf  [NUM_IN];

  logic signed [DATA_W-1:0]   x_q;
  logic signed [DATA_W-1:0]   w_q  [LANES];
  logic signed [2*DATA_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0]    acc  [LANES];

  logic              x_fire, y_fire;
  logic              layer_hit, cfg_ok;
  logic [LANE_W-1:0] c_lane;
  logic [WA_W-1:0]   c_word;
  logic [NB_W-1:0]   c_bias;
  logic [WA_W-1:0]   raddr;
  logic [LANE_W-1:0] sel;
  logic [NB_W-1:0]   bsel;
  logic [15:0]       sel_idx;
  logic signed [DATA_W-1:0] sel_res;

  assign x_fire    = x_valid && x_ready;
  assign y_fire    = y_valid && y_ready;
  assign busy      = !(state == S_LOAD && count == '0);
  assign layer_hit = cfg_layer == 32'(LAYER_ID);
  assign cfg_ok    = cfg_wr && layer_hit && !busy && cfg_addr < TOTAL;

  function automatic logic signed [DATA_W-1:0] requant(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    logic signed [ACC_W:0] r;
    s = (ACC_W + 1)'(a) + ((ACC_W + 1)'(b) <<< FRAC_W);
    r = s >>> FRAC_W;
    if (r > SAT_HI)      r = SAT_HI;
    else if (r < SAT_LO) r = SAT_LO;
    if (ACT != 0 && r < 0) r = '0;
    return r[DATA_W-1:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_LOAD: if (x_fire && count == LAST_K) state_next = S_MAC;
      S_MAC:  if (mcnt == MAC_END) state_next = S_EMIT;
      S_EMIT: if (y_fire && lane == LAST_LANE)
                state_next = (pass == LAST_PASS) ? S_LOAD : S_MAC;
      default: state_next = S_LOAD;
    endcase
  end

  // Config address decode into weight bank/row or bias slot
  always_comb begin
    c_lane = LANE_W'((cfg_addr / 32'(NUM_IN)) % 32'(LANES));
    c_word = WA_W'((cfg_addr / 32'(NUM_IN)) / 32'(LANES) * 32'(NUM_IN)
                   + cfg_addr % 32'(NUM_IN));
    c_bias = NB_W'(cfg_addr - W_WORDS);
  end

  // Coefficient memories: written only when idle, never cleared by reset
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      if (cfg_addr < W_WORDS) w_mem[c_lane][c_word] <= cfg_data;
      else                    b_mem[c_bias]         <= cfg_data;
    end
  end

  assign raddr = WA_W'(int'(pass) * NUM_IN + int'(mcnt));

  // Input buffer write and registered operand fetch for the MAC lanes
  always_ff @(posedge clk) begin
    if (state == S_LOAD && x_fire) xbuf[count] <= x_in;
    if (state == S_MAC && mcnt != MAC_END) begin
      x_q <= xbuf[mcnt];
      for (int unsigned l = 0; l < LANES; l++) w_q[l] <= w_mem[l][raddr];
    end
  end

  // Lane products
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) prod[l] = x_q * w_q[l];
  end

  // Output lane selection: preload the next lane while the current one handshakes
  always_comb begin
    sel     = (y_valid && lane != LAST_LANE) ? lane + 1'b1 : lane;
    bsel    = NB_W'(int'(pass) * LANES + int'(sel));
    sel_idx = 16'(int'(pass) * LANES + int'(sel));
    sel_res = requant(acc[sel], b_mem[bsel]);
  end

  // Counters, accumulators and the registered output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      mcnt       <= '0;
      pass       <= '0;
      lane       <= '0;
      x_ready    <= 1'b0;
      y_valid    <= 1'b0;
      y_data     <= '0;
      y_idx      <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      for (int unsigned l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= cfg_wr && layer_hit && !cfg_ok;
      x_ready    <= state_next == S_LOAD;

      if (state == S_LOAD && x_fire) count <= (count == LAST_K) ? '0 : count + 1'b1;

      if (state == S_MAC) mcnt <= (mcnt == MAC_END) ? '0 : mcnt + 1'b1;
      else                mcnt <= '0;

      // First MAC cycle only fetches; accumulation follows one cycle behind
      if (state_next == S_MAC && state != S_MAC) begin
        for (int unsigned l = 0; l < LANES; l++) acc[l] <= '0;
      end else if (state == S_MAC && mcnt != '0) begin
        for (int unsigned l = 0; l < LANES; l++) acc[l] <= acc[l] + ACC_W'(prod[l]);
      end

      if (state == S_EMIT) begin
        if (!y_valid) begin
          y_valid <= 1'b1;
          y_data  <= sel_res;
          y_idx   <= sel_idx;
        end else if (y_ready) begin
          if (lane == LAST_LANE) begin
            y_valid <= 1'b0;
            lane    <= '0;
            if (pass == LAST_PASS) begin
              pass       <= '0;
              frame_done <= 1'b1;
            end else begin
              pass <= pass + 1'b1;
            end
          end else begin
            lane   <= lane + 1'b1;
            y_data <= sel_res;
            y_idx  <= sel_idx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Bench for mlp_layer_seq: a ReLU and an identity instance run in lockstep
// against a plain-arithmetic model of the layer.
module tb_mlp_layer_seq;

  localparam int NI  = 4;
  localparam int NO  = 4;
  localparam int LN  = 2;
  localparam int DW  = 16;
  localparam int FW  = 12;
  localparam int LID = 1;
  localparam int NWORDS = NO * NI + NO;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [31:0]   cfg_layer = '0;
  logic [31:0]   cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          x_valid = 1'b0;
  logic [DW-1:0] x_in = '0;
  logic          y_ready = 1'b0;

  logic          r_cfg_err, r_x_ready, r_y_valid, r_busy, r_frame_done;
  logic [DW-1:0] r_y_data;
  logic [15:0]   r_y_idx;
  logic          l_cfg_err, l_x_ready, l_y_valid, l_busy, l_frame_done;
  logic [DW-1:0] l_y_data;
  logic [15:0]   l_y_idx;

  mlp_layer_seq #(.NUM_IN(NI), .NUM_OUT(NO), .LANES(LN), .DATA_W(DW), .FRAC_W(FW),
                  .LAYER_ID(LID), .ACT(1)) u_relu (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_layer(cfg_layer), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(r_cfg_err), .x_valid(x_valid), .x_ready(r_x_ready),
    .x_in(x_in), .y_valid(r_y_valid), .y_ready(y_ready), .y_data(r_y_data),
    .y_idx(r_y_idx), .busy(r_busy), .frame_done(r_frame_done));

  mlp_layer_seq #(.NUM_IN(NI), .NUM_OUT(NO), .LANES(LN), .DATA_W(DW), .FRAC_W(FW),
                  .LAYER_ID(LID), .ACT(0)) u_lin (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_layer(cfg_layer), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(l_cfg_err), .x_valid(x_valid), .x_ready(l_x_ready),
    .x_in(x_in), .y_valid(l_y_valid), .y_ready(y_ready), .y_data(l_y_data),
    .y_idx(l_y_idx), .busy(l_busy), .frame_done(l_frame_done));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned t_last = 0;
  int fd_r = 0;
  int fd_l = 0;
  int n_chk = 0;
  int n_bad = 0;

  int mw [NO][NI];
  int mb [NO];
  int xv [NI];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (r_frame_done) fd_r++;
    if (l_frame_done) fd_l++;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Dot product plus bias in plain integer arithmetic, floor-divided by 2^FW
  function automatic longint ref_y(input int n, input bit relu);
    longint s = 0;
    for (int k = 0; k < NI; k++) s += longint'(xv[k]) * longint'(mw[n][k]);
    s += longint'(mb[n]) * (longint'(1) << FW);
    s = s >>> FW;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic cfg_write(input int layer, input int addr, input int data, input bit idle);
    bit exp_err;
    exp_err   = (layer == LID) && (!idle || addr >= NWORDS);
    cfg_wr    = 1'b1;
    cfg_layer = 32'(layer);
    cfg_addr  = 32'(addr);
    cfg_data  = 16'(data);
    @(negedge clk);
    cfg_wr = 1'b0;
    chk("cfg_err_relu", r_cfg_err, exp_err);
    chk("cfg_err_lin", l_cfg_err, exp_err);
    if (exp_err) begin
      @(negedge clk);
      chk("cfg_err_pulse", r_cfg_err, 0);
    end
    if (layer == LID && !exp_err) begin
      if (addr < NO * NI) mw[addr / NI][addr % NI] = data;
      else                mb[addr - NO * NI] = data;
    end
  endtask

  task automatic load_all(input int wval, input int bval);
    for (int a = 0; a < NWORDS; a++) cfg_write(LID, a, (a < NO * NI) ? wval : bval, 1'b1);
  endtask

  task automatic send_frame();
    for (int b = 0; b < NI; b++) begin
      int guard = 0;
      while (!r_x_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (!r_x_ready) chk("x_ready_timeout", 0, 1);
      x_valid = 1'b1;
      x_in    = 16'(xv[b]);
      @(negedge clk);
    end
    x_valid = 1'b0;
    t_last  = cyc;
  endtask

  task automatic collect_frame(input bit chk_lat, input int stall_i, input int stall_n);
    int fd0 = fd_r;
    int fl0 = fd_l;
    for (int i = 0; i < NO; i++) begin
      int guard = 0;
      int d;
      while (!r_y_valid && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!r_y_valid) begin
        chk("y_valid_timeout", 0, 1);
        return;
      end
      if (i == 0 && chk_lat) chk("first_latency", longint'(cyc - t_last), NI + 2);
      chk("y_idx_relu", r_y_idx, i);
      chk("y_idx_lin", l_y_idx, i);
      chk("y_valid_lin", l_y_valid, 1);
      chk("y_data_relu", $signed(r_y_data), ref_y(i, 1'b1));
      chk("y_data_lin", $signed(l_y_data), ref_y(i, 1'b0));
      d = (i == stall_i) ? stall_n : int'($urandom_range(0, 2));
      repeat (d) begin
        @(negedge clk);
        chk("hold_valid", r_y_valid, 1);
        chk("hold_idx", r_y_idx, i);
        chk("hold_data", $signed(r_y_data), ref_y(i, 1'b1));
      end
      y_ready = 1'b1;
      @(negedge clk);
      y_ready = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("frame_done_relu", fd_r - fd0, 1);
    chk("frame_done_lin", fd_l - fl0, 1);
    chk("idle_busy", r_busy, 0);
    chk("idle_x_ready", r_x_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_x_ready", r_x_ready, 0);
    chk("rst_y_valid", r_y_valid, 0);
    chk("rst_busy", r_busy, 0);
    chk("rst_y_data", r_y_data, 0);
    chk("rst_y_idx", r_y_idx, 0);
    chk("rst_cfg_err", r_cfg_err, 0);
    chk("rst_frame_done", r_frame_done, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("x_ready_after_rst", r_x_ready, 1);

    // Uniform weights 1.0, bias 0.5
    load_all(4096, 2048);
    xv = '{4096, 8192, 2048, 2048};
    send_frame();
    collect_frame(1'b1, -1, 0);

    // Reset in the middle of MAC, then a full frame with retained weights
    send_frame();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_x_ready", r_x_ready, 0);
    chk("midrst_y_valid", r_y_valid, 0);
    chk("midrst_busy", r_busy, 0);
    chk("midrst_y_data", r_y_data, 0);
    chk("midrst_y_idx", r_y_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("postrst_x_ready", r_x_ready, 1);
    send_frame();
    collect_frame(1'b1, -1, 0);

    // Backpressure on lane 1 of pass 0
    send_frame();
    collect_frame(1'b1, 1, 5);

    // Negative neuron 2 exercises ReLU vs identity
    for (int k = 0; k < NI; k++) cfg_write(LID, 2 * NI + k, -4096, 1'b1);
    cfg_write(LID, NO * NI + 2, 0, 1'b1);
    send_frame();
    collect_frame(1'b0, -1, 0);

    // Saturation both ways
    load_all(28672, 0);
    xv = '{28672, 28672, 28672, 28672};
    send_frame();
    collect_frame(1'b0, -1, 0);
    load_all(-28672, 0);
    send_frame();
    collect_frame(1'b0, -1, 0);

    // Config rejection during MAC, out-of-range address, foreign layer
    load_all(4096, 2048);
    xv = '{4096, 8192, 2048, 2048};
    send_frame();
    cfg_write(LID, 3, 1234, 1'b0);
    cfg_write(2, 3, 1234, 1'b0);
    collect_frame(1'b0, -1, 0);
    cfg_write(LID, NWORDS, 55, 1'b1);
    cfg_write(2, 0, 999, 1'b1);
    cfg_write(LID, NWORDS - 1, -100, 1'b1);
    send_frame();
    collect_frame(1'b0, -1, 0);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      for (int a = 0; a < NWORDS; a++) begin
        int v = (f < 4) ? int'($urandom_range(0, 16383)) - 8192
                        : int'($urandom_range(0, 65535)) - 32768;
        cfg_write(LID, a, v, 1'b1);
      end
      if (f % 2 == 1) cfg_write(3, int'($urandom_range(0, NWORDS - 1)), 77, 1'b1);
      for (int k = 0; k < NI; k++) xv[k] = int'($urandom_range(0, 65535)) - 32768;
      send_frame();
      collect_frame(1'b1, int'($urandom_range(0, NO - 1)), int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
